// File: rtl/c7bexu_wb.sv
// Writeback merge for the dual-issue execute unit: two never-stalled pipes plus a
// small FIFO of long-latency results, mapped onto two registered RF write ports.
module c7bexu_wb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_valid,
    input  logic [4:0]  p0_waddr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_valid,
    input  logic [4:0]  p1_waddr,
    input  logic [31:0] p1_wdata,
    input  logic        lu_valid,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    output logic [4:0]  waddr1,
    output logic [31:0] wdata1,
    output logic        wen1,
    output logic [4:0]  waddr2,
    output logic [31:0] wdata2,
    output logic        wen2,
    output logic [31:0] lu_pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       fifo_addr_q [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d, kill;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, head1;
    logic [CW-1:0]    count_q, count_d;

    logic [4:0]  waddr1_q, waddr1_d, waddr2_q, waddr2_d;
    logic [31:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
    logic        wen1_q, wen1_d, wen2_q, wen2_d;

    logic        p0_w, p1_w, enq;
    logic [1:0]  npop;
    logic [31:0] pending;

    assign p0_w     = p0_valid && (p0_waddr != 5'd0);
    assign p1_w     = p1_valid && (p1_waddr != 5'd0);
    assign lu_ready = (count_q != CW'(DEPTH));
    assign head1    = head_q + 1'b1;

    // An entry dies when a younger pipe result targets the same register.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
        assign kill[gi] = (p0_w && (fifo_addr_q[gi] == p0_waddr)) ||
                          (p1_w && (fifo_addr_q[gi] == p1_waddr));
    end

    always_comb begin
        waddr1_d = 5'd0;
        wdata1_d = 32'd0;
        wen1_d   = 1'b0;
        waddr2_d = 5'd0;
        wdata2_d = 32'd0;
        wen2_d   = 1'b0;
        npop     = 2'd0;
        case ({p0_w, p1_w})
            2'b11: begin
                waddr1_d = p0_waddr;
                wdata1_d = p0_wdata;
                wen1_d   = 1'b1;
                waddr2_d = p1_waddr;
                wdata2_d = p1_wdata;
                wen2_d   = 1'b1;
            end
            2'b10, 2'b01: begin
                waddr2_d = p0_w ? p0_waddr : p1_waddr;
                wdata2_d = p0_w ? p0_wdata : p1_wdata;
                wen2_d   = 1'b1;
                if (count_q != '0) begin
                    waddr1_d = fifo_addr_q[head_q];
                    wdata1_d = fifo_data_q[head_q];
                    wen1_d   = live_q[head_q] && !kill[head_q];
                    npop     = 2'd1;
                end
            end
            default: begin
                if (count_q != '0) begin
                    waddr1_d = fifo_addr_q[head_q];
                    wdata1_d = fifo_data_q[head_q];
                    wen1_d   = live_q[head_q] && !kill[head_q];
                    npop     = 2'd1;
                end
                if (count_q >= CW'(2)) begin
                    waddr2_d = fifo_addr_q[head1];
                    wdata2_d = fifo_data_q[head1];
                    wen2_d   = live_q[head1] && !kill[head1];
                    npop     = 2'd2;
                end
            end
        endcase
    end

    // r0 and results already superseded by a same-cycle pipe write are accepted but dropped.
    always_comb begin
        enq = lu_valid && lu_ready && (lu_waddr != 5'd0) &&
              !(p0_w && (p0_waddr == lu_waddr)) &&
              !(p1_w && (p1_waddr == lu_waddr));
        count_d = count_q + CW'(enq) - CW'(npop);
        head_d  = head_q + PW'(npop);
        tail_d  = tail_q + PW'(enq);
        live_d  = live_q & ~kill;
        if (npop != 2'd0) live_d[head_q] = 1'b0;
        if (npop == 2'd2) live_d[head1]  = 1'b0;
        if (enq)          live_d[tail_q] = 1'b1;
    end

    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) pending[fifo_addr_q[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            live_q   <= '0;
            waddr1_q <= 5'd0;
            wdata1_q <= 32'd0;
            wen1_q   <= 1'b0;
            waddr2_q <= 5'd0;
            wdata2_q <= 32'd0;
            wen2_q   <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            live_q   <= live_d;
            waddr1_q <= waddr1_d;
            wdata1_q <= wdata1_d;
            wen1_q   <= wen1_d;
            waddr2_q <= waddr2_d;
            wdata2_q <= wdata2_d;
            wen2_q   <= wen2_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count and live bits.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[tail_q] <= lu_waddr;
            fifo_data_q[tail_q] <= lu_wdata;
        end
    end

    assign waddr1     = waddr1_q;
    assign wdata1     = wdata1_q;
    assign wen1       = wen1_q;
    assign waddr2     = waddr2_q;
    assign wdata2     = wdata2_q;
    assign wen2       = wen2_q;
    assign lu_pending = pending;
endmodule
